// File: rtl/br_outcome_queue_pkg.sv
// Shared types and defaults for the branch outcome queue.
// Optional feature macro: BR_OUTCOME_STATS_EN (commit / mispredict counters).
package br_outcome_queue_pkg;

  // Architectural register / PC width
  typedef logic [31:0] reg_t;

  // Default ROB tag width and queue depth
  localparam int ROB_ID_W_DEF  = 4;
  localparam int BR_QUEUE_SIZE = 8;

  typedef logic [ROB_ID_W_DEF-1:0] rob_id_t;

  // One in-flight branch; the ROB tag lives in a separate array so its
  // width can follow the top-level parameter.
  typedef struct packed {
    logic valid;
    logic resolved;
    reg_t pc;
    logic pred_taken;
    logic taken;
    reg_t target;
  } br_entry_t;

  // Corrected fetch PC after a mispredict: fall-through wraps at 32 bits.
  function automatic reg_t fix_pc(input logic taken, input reg_t target, input reg_t pc);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/br_stat_counters.sv
// Committed-branch and mispredict counters; 32-bit wrapping, cleared by rst only.
module br_stat_counters
  import br_outcome_queue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        br_inc,
  input  logic        mp_inc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  // Count honoured commits and flushes; increments are already rdy-qualified.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (br_inc) stat_branches    <= stat_branches + 32'd1;
      if (mp_inc) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule

// File: rtl/br_outcome_queue.sv
// Program-ordered queue of in-flight conditional branches. Records PC and
// predicted direction at issue, captures ALU outcome by ROB tag, and on ROB
// commit drives one registered predictor update plus a flush on mispredict.
// Optional feature macro: BR_OUTCOME_STATS_EN (adds br_stat_counters).
module br_outcome_queue
  import br_outcome_queue_pkg::*;
#(
  parameter int DEPTH        = BR_QUEUE_SIZE,
  parameter int ROB_ID_WIDTH = ROB_ID_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic [31:0]             alloc_pc,
  input  logic                    alloc_pred_taken,
  input  logic [ROB_ID_WIDTH-1:0] alloc_rob_id,
  input  logic                    res_valid,
  input  logic [ROB_ID_WIDTH-1:0] res_rob_id,
  input  logic                    res_taken,
  input  logic [31:0]             res_target,
  output logic                    head_valid,
  output logic [ROB_ID_WIDTH-1:0] head_rob_id,
  input  logic                    commit_valid,
  input  logic                    clear,
  output logic                    valid_to_predictor,
  output logic [31:0]             pc_to_predictor,
  output logic                    is_taken_to_predictor,
  output logic                    flush,
  output logic [31:0]             flush_pc,
  output logic [31:0]             stat_branches,
  output logic [31:0]             stat_mispredicts
);

  localparam int PW = $clog2(DEPTH);

  br_entry_t               q    [DEPTH];
  logic [ROB_ID_WIDTH-1:0] q_id [DEPTH];
  logic [PW-1:0]           head, tail;
  logic [PW:0]             count;

  logic          full;
  logic          commit_fire, mispred, flush_now, alloc_fire;
  logic          res_hit;
  logic [PW-1:0] res_idx;

  assign full        = (count == (PW+1)'(DEPTH));
  assign alloc_ready = !full;
  assign head_valid  = q[head].valid && q[head].resolved;
  assign head_rob_id = q[head].valid ? q_id[head] : '0;

  // A commit is honoured only for a resolved head; clear discards it.
  assign commit_fire = rdy && commit_valid && head_valid && !clear;
  assign mispred     = q[head].pred_taken != q[head].taken;
  assign flush_now   = commit_fire && mispred;
  // Full queue still accepts when the head pops; younger-than-mispredict
  // and same-cycle-as-clear allocations are dropped.
  assign alloc_fire  = rdy && alloc_valid && (!full || commit_fire) && !clear && !flush_now;

  // Tag CAM over valid entries; lowest matching slot wins.
  always_comb begin
    res_hit = 1'b0;
    res_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (res_valid && q[i].valid && (q_id[i] == res_rob_id)) begin
        res_hit = 1'b1;
        res_idx = PW'(i);
      end
    end
  end

  // Queue storage and pointers; a flush or clear empties everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i]    <= '0;
        q_id[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (clear || flush_now) begin
        for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (res_hit) begin
          q[res_idx].resolved <= 1'b1;
          q[res_idx].taken    <= res_taken;
          q[res_idx].target   <= res_target;
        end
        if (commit_fire) begin
          q[head].valid <= 1'b0;
          head          <= head + PW'(1);
        end
        // Written last so a full-queue alloc into the popping slot wins.
        if (alloc_fire) begin
          q[tail]    <= '{valid: 1'b1, resolved: 1'b0, pc: alloc_pc,
                          pred_taken: alloc_pred_taken, taken: 1'b0, target: '0};
          q_id[tail] <= alloc_rob_id;
          tail       <= tail + PW'(1);
        end
        count <= count + (PW+1)'(alloc_fire) - (PW+1)'(commit_fire);
      end
    end
  end

  // Registered predictor update and flush; held while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_to_predictor    <= 1'b0;
      pc_to_predictor       <= '0;
      is_taken_to_predictor <= 1'b0;
      flush                 <= 1'b0;
      flush_pc              <= '0;
    end else if (rdy) begin
      valid_to_predictor <= commit_fire;
      flush              <= flush_now;
      if (commit_fire) begin
        pc_to_predictor       <= q[head].pc;
        is_taken_to_predictor <= q[head].taken;
      end
      if (flush_now) flush_pc <= fix_pc(q[head].taken, q[head].target, q[head].pc);
    end
  end

`ifdef BR_OUTCOME_STATS_EN
  br_stat_counters u_stats (
    .clk              (clk),
    .rst              (rst),
    .br_inc           (commit_fire),
    .mp_inc           (flush_now),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_br_outcome_queue.sv
// Directed bench for br_outcome_queue with a queue-based reference model
// and a per-cycle compare process.
module tb_br_outcome_queue;

  localparam int DEPTH = 8;
  localparam int RW    = 4;

  logic          clk = 0, rst = 0, rdy = 1;
  logic          alloc_valid = 0, alloc_pred_taken = 0;
  logic [31:0]   alloc_pc = 0;
  logic [RW-1:0] alloc_rob_id = 0;
  logic          res_valid = 0, res_taken = 0;
  logic [RW-1:0] res_rob_id = 0;
  logic [31:0]   res_target = 0;
  logic          commit_valid = 0, clear = 0;
  logic          alloc_ready, head_valid;
  logic [RW-1:0] head_rob_id;
  logic          valid_to_predictor, is_taken_to_predictor, flush;
  logic [31:0]   pc_to_predictor, flush_pc, stat_branches, stat_mispredicts;

  br_outcome_queue #(.DEPTH(DEPTH), .ROB_ID_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_pred_taken(alloc_pred_taken), .alloc_rob_id(alloc_rob_id),
    .res_valid(res_valid), .res_rob_id(res_rob_id), .res_taken(res_taken),
    .res_target(res_target), .head_valid(head_valid), .head_rob_id(head_rob_id),
    .commit_valid(commit_valid), .clear(clear),
    .valid_to_predictor(valid_to_predictor), .pc_to_predictor(pc_to_predictor),
    .is_taken_to_predictor(is_taken_to_predictor), .flush(flush), .flush_pc(flush_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit [31:0]   pc;
    bit          pred;
    bit          res;
    bit          taken;
    bit [31:0]   tgt;
    bit [RW-1:0] id;
  } ent_t;

  ent_t      mq[$];
  bit        e_vtp, e_tk, e_fl;
  bit [31:0] e_pc, e_fpc, e_sb, e_sm;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      e_vtp = 0; e_tk = 0; e_fl = 0; e_pc = 0; e_fpc = 0; e_sb = 0; e_sm = 0;
    end else if (rdy) begin
      bit hv, cm, mis, was_full;
      hv       = mq.size() > 0 && mq[0].res;
      cm       = commit_valid && hv && !clear;
      mis      = cm && (mq[0].pred != mq[0].taken);
      was_full = mq.size() >= DEPTH;
      e_vtp = cm;
      e_fl  = mis;
      if (cm) begin
        e_pc = mq[0].pc;
        e_tk = mq[0].taken;
        e_sb++;
      end
      if (mis) begin
        e_fpc = mq[0].taken ? mq[0].tgt : mq[0].pc + 32'd4;
        e_sm++;
      end
      if (clear || mis) mq.delete();
      else begin
        if (res_valid) begin
          for (int i = 0; i < mq.size(); i++)
            if (mq[i].id == res_rob_id) begin
              mq[i].res = 1; mq[i].taken = res_taken; mq[i].tgt = res_target;
              break;
            end
        end
        if (cm) void'(mq.pop_front());
        if (alloc_valid && (!was_full || cm)) begin
          ent_t e;
          e.pc = alloc_pc; e.pred = alloc_pred_taken; e.res = 0;
          e.taken = 0; e.tgt = 0; e.id = alloc_rob_id;
          mq.push_back(e);
        end
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    bit [31:0] esb, esm;
`ifdef BR_OUTCOME_STATS_EN
    esb = e_sb; esm = e_sm;
`else
    esb = 0; esm = 0;
`endif
    chk("alloc_ready", {31'd0, alloc_ready}, {31'd0, mq.size() < DEPTH});
    chk("head_valid",  {31'd0, head_valid},  {31'd0, mq.size() > 0 && mq[0].res});
    chk("head_rob_id", {28'd0, head_rob_id}, mq.size() > 0 ? {28'd0, mq[0].id} : 32'd0);
    chk("valid_to_predictor", {31'd0, valid_to_predictor}, {31'd0, e_vtp});
    chk("pc_to_predictor", pc_to_predictor, e_pc);
    chk("is_taken", {31'd0, is_taken_to_predictor}, {31'd0, e_tk});
    chk("flush", {31'd0, flush}, {31'd0, e_fl});
    chk("flush_pc", flush_pc, e_fpc);
    chk("stat_branches", stat_branches, esb);
    chk("stat_mispredicts", stat_mispredicts, esm);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; res_valid = 0; commit_valid = 0; clear = 0;
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic pred, input logic [RW-1:0] id);
    alloc_valid = 1; alloc_pc = pc; alloc_pred_taken = pred; alloc_rob_id = id;
    cyc(); idle_inputs();
  endtask

  task automatic do_res(input logic [RW-1:0] id, input logic tk, input logic [31:0] tgt);
    res_valid = 1; res_rob_id = id; res_taken = tk; res_target = tgt;
    cyc(); idle_inputs();
  endtask

  task automatic do_commit();
    commit_valid = 1;
    cyc(); idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    rst = 0; cyc(); cyc(); rst = 1; cyc();
    chk("lit_reset_ready", {31'd0, alloc_ready}, 32'd1);
    chk("lit_reset_vtp", {31'd0, valid_to_predictor}, 32'd0);

    // Correct taken branch
    do_alloc(32'h100, 1, 3);
    do_res(3, 1, 32'h80);
    chk("lit_head_id3", {28'd0, head_rob_id}, 32'd3);
    do_commit();
    chk("lit_t1_vtp", {31'd0, valid_to_predictor}, 32'd1);
    chk("lit_t1_pc", pc_to_predictor, 32'h100);
    chk("lit_t1_flush", {31'd0, flush}, 32'd0);
    cyc();
    chk("lit_t1_vtp_drop", {31'd0, valid_to_predictor}, 32'd0);

    // Mispredict not-taken, with an alloc in the commit cycle (dropped)
    do_alloc(32'h200, 1, 5);
    do_alloc(32'h300, 0, 6);
    do_alloc(32'h304, 0, 7);
    do_res(5, 0, 32'h999);
    commit_valid = 1; alloc_valid = 1; alloc_pc = 32'h400; alloc_rob_id = 8;
    cyc(); idle_inputs();
    chk("lit_t2_flush", {31'd0, flush}, 32'd1);
    chk("lit_t2_fpc", flush_pc, 32'h204);
    chk("lit_t2_tk", {31'd0, is_taken_to_predictor}, 32'd0);
    chk("lit_t2_empty", {28'd0, head_rob_id}, 32'd0);
    cyc();

    // Out-of-order resolve; a commit on an unresolved head is ignored
    do_alloc(32'h10, 0, 1);
    do_alloc(32'h14, 0, 2);
    do_alloc(32'h18, 0, 3);
    res_valid = 1; res_rob_id = 3; res_taken = 0; commit_valid = 1;
    cyc(); idle_inputs();
    chk("lit_t3_hv0", {31'd0, head_valid}, 32'd0);
    do_res(2, 0, 0);
    chk("lit_t3_hv1", {31'd0, head_valid}, 32'd0);
    do_res(1, 0, 0);
    chk("lit_t3_hv2", {31'd0, head_valid}, 32'd1);
    do_commit(); chk("lit_t3_pc1", pc_to_predictor, 32'h10);
    do_commit(); chk("lit_t3_pc2", pc_to_predictor, 32'h14);
    do_commit(); chk("lit_t3_pc3", pc_to_predictor, 32'h18);
    cyc();

    // Full queue, alloc+commit while full, pointer wrap
    for (int i = 0; i < DEPTH; i++) do_alloc(32'h1000 + 32'(4*i), 0, RW'(i));
    chk("lit_t4_full", {31'd0, alloc_ready}, 32'd0);
    do_res(0, 0, 0);
    commit_valid = 1; alloc_valid = 1; alloc_pc = 32'h2000; alloc_pred_taken = 0; alloc_rob_id = 9;
    cyc(); idle_inputs();
    chk("lit_t4_still_full", {31'd0, alloc_ready}, 32'd0);
    for (int i = 1; i < DEPTH; i++) do_res(RW'(i), 0, 0);
    do_res(9, 0, 0);
    for (int i = 0; i < DEPTH; i++) do_commit();
    chk("lit_t4_last_pc", pc_to_predictor, 32'h2000);
    cyc();

    // rdy low holds the strobe and blocks state change
    do_alloc(32'h500, 0, 2);
    do_res(2, 0, 0);
    do_commit();
    rdy = 0; alloc_valid = 1; alloc_pc = 32'h600; alloc_rob_id = 4;
    cyc(); idle_inputs();
    chk("lit_rdy_hold", {31'd0, valid_to_predictor}, 32'd1);
    rdy = 1; cyc();
    chk("lit_rdy_drop", {31'd0, valid_to_predictor}, 32'd0);

    // Reset mid-operation
    do_alloc(32'h700, 0, 1);
    do_alloc(32'h704, 0, 2);
    #1 rst = 0; #1;
    chk("lit_midrst_ready", {31'd0, alloc_ready}, 32'd1);
    chk("lit_midrst_hv", {31'd0, head_valid}, 32'd0);
    cyc(); rst = 1; cyc();

    // Clear with 3 pending, then one correct and one mispredicted commit
    do_alloc(32'h10, 0, 1);
    do_alloc(32'h14, 0, 2);
    do_alloc(32'h18, 0, 3);
    do_res(1, 0, 0);
    clear = 1; commit_valid = 1;
    cyc(); idle_inputs();
    chk("lit_t5_noupd", {31'd0, valid_to_predictor}, 32'd0);
    chk("lit_t5_noflush", {31'd0, flush}, 32'd0);
    do_alloc(32'h700, 1, 4);
    do_alloc(32'h800, 0, 5);
    do_res(4, 1, 32'h40);
    do_res(5, 1, 32'h900);
    do_commit();
    do_commit();
    chk("lit_t5_fpc", flush_pc, 32'h900);
`ifdef BR_OUTCOME_STATS_EN
    chk("lit_t5_sb", stat_branches, 32'd2);
    chk("lit_t5_sm", stat_mispredicts, 32'd1);
`endif
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
